// File: rtl/pmem_arb_pkg.sv
// pmem_arb_pkg: shared FSM/owner types and burst geometry for the pmem arbiter
package pmem_arb_pkg;
  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_e;
  typedef enum logic {OWN_I, OWN_D} owner_e;
  localparam int BEATS = 4;
  localparam int BEAT_IDX_BITS = 2;
  localparam int LINE_OFFSET = 5;
endpackage

// File: rtl/pmem_burst_engine.sv
// pmem_burst_engine: runs one 4-beat pmem burst, shifting beats in/out of a line buffer
module pmem_burst_engine
  import pmem_arb_pkg::*;
#(
  parameter int ADDR_BITS = 32,
  parameter int LINE_BITS = 256,
  parameter int BEAT_BITS = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 we_i,
  input  logic [ADDR_BITS-1:0] addr_i,
  input  logic [LINE_BITS-1:0] wline_i,
  input  logic                 pmem_resp_i,
  input  logic [BEAT_BITS-1:0] pmem_rdata_i,
  output logic                 pmem_read_o,
  output logic                 pmem_write_o,
  output logic [ADDR_BITS-1:0] pmem_address_o,
  output logic [BEAT_BITS-1:0] pmem_wdata_o,
  output logic                 done_o,
  output logic [LINE_BITS-1:0] line_o
);
  logic [BEAT_IDX_BITS-1:0] beat_q;
  logic [LINE_BITS-1:0] line_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [BEAT_BITS-1:0] wdata_q;
  logic read_q, write_q, beat_ok;
  assign beat_ok = (read_q || write_q) && pmem_resp_i;
  assign done_o = beat_ok && beat_q == BEAT_IDX_BITS'(BEATS - 1);
  assign line_o = {pmem_rdata_i, line_q[LINE_BITS-1:BEAT_BITS]};
  assign pmem_read_o = read_q;
  assign pmem_write_o = write_q;
  assign pmem_address_o = addr_q;
  assign pmem_wdata_o = wdata_q;
  // Load the line at grant, then shift one beat per pmem_resp; reads enter at the top so beat 0 ends in the low bits
  always_ff @(posedge clk) begin
    if (rst) begin
      read_q  <= 1'b0;
      write_q <= 1'b0;
      beat_q  <= '0;
      line_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (start_i) begin
      read_q  <= !we_i;
      write_q <= we_i;
      beat_q  <= '0;
      line_q  <= wline_i;
      addr_q  <= addr_i & ~ADDR_BITS'(2 ** LINE_OFFSET - 1);
      wdata_q <= wline_i[BEAT_BITS-1:0];
    end else if (beat_ok) begin
      beat_q <= beat_q + BEAT_IDX_BITS'(1);
      line_q <= line_o;
      if (write_q) wdata_q <= line_q[2*BEAT_BITS-1:BEAT_BITS];
      if (done_o) begin
        read_q  <= 1'b0;
        write_q <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/pmem_arbiter.sv
// pmem_arbiter: fixed-priority I/D cache arbiter onto one burst pmem port (perf counters under PMEM_ARB_PERF_EN)
module pmem_arbiter
  import pmem_arb_pkg::*;
#(
  parameter int ADDR_BITS = 32,
  parameter int LINE_BITS = 256,
  parameter int BEAT_BITS = 64
`ifdef PMEM_ARB_PERF_EN
  , parameter int CNT_BITS = 32
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_read,
  input  logic [ADDR_BITS-1:0] i_address,
  output logic [LINE_BITS-1:0] i_rdata,
  output logic                 i_resp,
  input  logic                 d_read,
  input  logic                 d_write,
  input  logic [ADDR_BITS-1:0] d_address,
  input  logic [LINE_BITS-1:0] d_wdata,
  output logic [LINE_BITS-1:0] d_rdata,
  output logic                 d_resp,
  output logic                 pmem_read,
  output logic                 pmem_write,
  output logic [ADDR_BITS-1:0] pmem_address,
  output logic [BEAT_BITS-1:0] pmem_wdata,
  input  logic [BEAT_BITS-1:0] pmem_rdata,
`ifdef PMEM_ARB_PERF_EN
  input  logic                 pmem_resp,
  output logic [CNT_BITS-1:0]  perf_i_fills,
  output logic [CNT_BITS-1:0]  perf_d_xfers,
  output logic [CNT_BITS-1:0]  perf_wait_cyc
`else
  input  logic                 pmem_resp
`endif
);
  state_e state_q, state_d;
  owner_e owner_q, owner_d;
  logic start, done, i_resp_q, d_resp_q;
  logic [LINE_BITS-1:0] line, i_rdata_q, d_rdata_q;
  // Grant only from IDLE; DONE always returns to IDLE so a just-served request is never re-granted
  always_comb begin
    start   = state_q == IDLE && (d_write || d_read || i_read);
    owner_d = start ? ((d_write || d_read) ? OWN_D : OWN_I) : owner_q;
    state_d = start ? (d_write ? WR : RD) : state_q == DONE ? IDLE : done ? DONE : state_q;
  end
  // State and owner registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= OWN_I;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end
  pmem_burst_engine #(.ADDR_BITS(ADDR_BITS), .LINE_BITS(LINE_BITS), .BEAT_BITS(BEAT_BITS)) u_eng (
    .clk(clk), .rst(rst), .start_i(start), .we_i(d_write),
    .addr_i(owner_d == OWN_D ? d_address : i_address), .wline_i(d_wdata),
    .pmem_resp_i(pmem_resp), .pmem_rdata_i(pmem_rdata),
    .pmem_read_o(pmem_read), .pmem_write_o(pmem_write),
    .pmem_address_o(pmem_address), .pmem_wdata_o(pmem_wdata),
    .done_o(done), .line_o(line)
  );
  // Route the completion pulse and assembled read line to the owning client during DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      i_resp_q  <= 1'b0;
      d_resp_q  <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      i_resp_q <= done && owner_q == OWN_I;
      d_resp_q <= done && owner_q == OWN_D;
      if (done && state_q == RD && owner_q == OWN_I) i_rdata_q <= line;
      if (done && state_q == RD && owner_q == OWN_D) d_rdata_q <= line;
    end
  end
  assign i_resp = i_resp_q;
  assign d_resp = d_resp_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  // Both D request lines high together is a D-cache protocol error
  always_ff @(posedge clk) begin
    if (!rst) assert (!(d_read && d_write));
  end
`ifdef PMEM_ARB_PERF_EN
  logic [CNT_BITS-1:0] fills_q, xfers_q, wait_q;
  logic wait_inc;
  assign wait_inc = state_q != IDLE && (owner_q == OWN_D ? i_read : (d_read || d_write));
  // Saturating event counters
  always_ff @(posedge clk) begin
    if (rst) begin
      fills_q <= '0;
      xfers_q <= '0;
      wait_q  <= '0;
    end else begin
      if (state_q == DONE && owner_q == OWN_I && !(&fills_q)) fills_q <= fills_q + CNT_BITS'(1);
      if (state_q == DONE && owner_q == OWN_D && !(&xfers_q)) xfers_q <= xfers_q + CNT_BITS'(1);
      if (wait_inc && !(&wait_q)) wait_q <= wait_q + CNT_BITS'(1);
    end
  end
  assign perf_i_fills = fills_q;
  assign perf_d_xfers = xfers_q;
  assign perf_wait_cyc = wait_q;
`endif
endmodule

// File: tb/tb_pmem_arbiter.sv
// tb_pmem_arbiter: directed checks of arbitration, burst framing and reset for pmem_arbiter
module tb_pmem_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic i_read, d_read, d_write, i_resp, d_resp;
  logic [31:0] i_address, d_address, pmem_address;
  logic [255:0] i_rdata, d_rdata, d_wdata;
  logic pmem_read, pmem_write;
  logic pmem_resp = 1'b0;
  logic [63:0] pmem_rdata = '0;
  logic [63:0] pmem_wdata;
`ifdef PMEM_ARB_PERF_EN
  logic [31:0] perf_i_fills, perf_d_xfers, perf_wait_cyc;
`endif
  int vectors = 0;
  int miscompares = 0;
  int gap = 1;
  logic [63:0] mem_tag = '0;
  int mcyc = 0;
  int mnb = 0;
  logic [31:0] exp_addr;
  logic [63:0] wlog [0:7];
  int wn = 0;
  int cyc, rdhi, abad;
  bit got_i, got_d;

  pmem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata),
`ifdef PMEM_ARB_PERF_EN
    .pmem_resp(pmem_resp), .perf_i_fills(perf_i_fills), .perf_d_xfers(perf_d_xfers),
    .perf_wait_cyc(perf_wait_cyc)
`else
    .pmem_resp(pmem_resp)
`endif
  );

  always #5 clk = ~clk;

  // Memory model: with burst cycle 1 being the first cycle pmem_read/write is high,
  // a beat is returned in every cycle j>1 with j % gap == 0, four beats per burst.
  always @(posedge clk) begin
    if (rst || !(pmem_read || pmem_write)) begin
      mcyc = 0;
      mnb = 0;
      pmem_resp <= 1'b0;
    end else begin
      mcyc = mcyc + 1;
      if ((mcyc + 1) % gap == 0 && mcyc + 1 > 1 && mnb < 4) begin
        pmem_resp <= 1'b1;
        pmem_rdata <= mem_tag + 64'(mnb);
        mnb = mnb + 1;
      end else pmem_resp <= 1'b0;
    end
  end

  task automatic wait_resp(input int maxc);
    cyc = 0; rdhi = 0; abad = 0; got_i = 0; got_d = 0;
    while (cyc < maxc && !got_i && !got_d) begin
      @(negedge clk);
      cyc++;
      if (pmem_read) rdhi++;
      if ((pmem_read || pmem_write) && pmem_address !== exp_addr) abad++;
      if (pmem_resp && pmem_write && wn < 8) begin
        wlog[wn] = pmem_wdata;
        wn++;
      end
      got_i = i_resp;
      got_d = d_resp;
    end
    if (!got_i && !got_d) begin
      vectors++; miscompares++;
      $display("FAIL resp_timeout: no resp within %0d cycles", maxc);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors += 8;
    if (pmem_read !== 1'b0) begin miscompares++; $display("FAIL rst_pmem_read got %b want 0", pmem_read); end
    if (pmem_write !== 1'b0) begin miscompares++; $display("FAIL rst_pmem_write got %b want 0", pmem_write); end
    if (pmem_address !== 32'h0) begin miscompares++; $display("FAIL rst_pmem_address got %h want 0", pmem_address); end
    if (pmem_wdata !== 64'h0) begin miscompares++; $display("FAIL rst_pmem_wdata got %h want 0", pmem_wdata); end
    if (i_resp !== 1'b0) begin miscompares++; $display("FAIL rst_i_resp got %b want 0", i_resp); end
    if (d_resp !== 1'b0) begin miscompares++; $display("FAIL rst_d_resp got %b want 0", d_resp); end
    if (i_rdata !== 256'h0) begin miscompares++; $display("FAIL rst_i_rdata got %h want 0", i_rdata); end
    if (d_rdata !== 256'h0) begin miscompares++; $display("FAIL rst_d_rdata got %h want 0", d_rdata); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_i_fill;
    mem_tag = 64'hA0;
    i_address = 32'h0000_0064;
    exp_addr = 32'h0000_0060;
    i_read = 1'b1;
    wait_resp(40);
    i_read = 1'b0;
    vectors += 6;
    if (!(got_i && !got_d)) begin miscompares++; $display("FAIL ifill_owner got i=%b d=%b want i=1 d=0", got_i, got_d); end
    if (cyc != 6) begin miscompares++; $display("FAIL ifill_latency got %0d want 6", cyc); end
    if (rdhi != 5) begin miscompares++; $display("FAIL ifill_read_cycles got %0d want 5", rdhi); end
    if (abad != 0) begin miscompares++; $display("FAIL ifill_addr got %0d bad cycles want 0", abad); end
    if (i_rdata !== {64'hA3, 64'hA2, 64'hA1, 64'hA0}) begin miscompares++; $display("FAIL ifill_line got %h want A3..A0", i_rdata); end
    if (pmem_read !== 1'b0) begin miscompares++; $display("FAIL ifill_read_dropped got %b want 0", pmem_read); end
    @(negedge clk);
    vectors++;
    if (i_resp !== 1'b0) begin miscompares++; $display("FAIL ifill_pulse_width got %b want 0", i_resp); end
  endtask

  task automatic test_d_write;
    wn = 0;
    d_wdata = {64'hD000_0000_0000_0003, 64'hD000_0000_0000_0002, 64'hD000_0000_0000_0001, 64'hD000_0000_0000_0000};
    d_address = 32'h0000_1234;
    exp_addr = 32'h0000_1220;
    d_write = 1'b1;
    wait_resp(40);
    d_write = 1'b0;
    vectors += 5;
    if (!(got_d && !got_i)) begin miscompares++; $display("FAIL dwr_owner got i=%b d=%b want i=0 d=1", got_i, got_d); end
    if (cyc != 6) begin miscompares++; $display("FAIL dwr_latency got %0d want 6", cyc); end
    if (wn != 4) begin miscompares++; $display("FAIL dwr_beats got %0d want 4", wn); end
    if (abad != 0) begin miscompares++; $display("FAIL dwr_addr got %0d bad cycles want 0", abad); end
    if (rdhi != 0) begin miscompares++; $display("FAIL dwr_no_read got %0d read cycles want 0", rdhi); end
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (wlog[k] !== (64'hD000_0000_0000_0000 | 64'(k))) begin
        miscompares++; $display("FAIL dwr_beat%0d got %h want %h", k, wlog[k], 64'hD000_0000_0000_0000 | 64'(k));
      end
    end
    @(negedge clk);
  endtask

  task automatic test_contention;
    mem_tag = 64'hB0;
    i_address = 32'h0000_0100;
    d_address = 32'h0000_0200;
    exp_addr = 32'h0000_0200;
    i_read = 1'b1;
    d_read = 1'b1;
    wait_resp(40);
    d_read = 1'b0;
    mem_tag = 64'hC0;
    vectors += 3;
    if (!(got_d && !got_i)) begin miscompares++; $display("FAIL cont_first got i=%b d=%b want i=0 d=1", got_i, got_d); end
    if (cyc != 6) begin miscompares++; $display("FAIL cont_d_latency got %0d want 6", cyc); end
    if (d_rdata !== {64'hB3, 64'hB2, 64'hB1, 64'hB0}) begin miscompares++; $display("FAIL cont_d_line got %h want B3..B0", d_rdata); end
    exp_addr = 32'h0000_0100;
    wait_resp(40);
    i_read = 1'b0;
    vectors += 3;
    if (!(got_i && !got_d)) begin miscompares++; $display("FAIL cont_second got i=%b d=%b want i=1 d=0", got_i, got_d); end
    if (cyc != 7) begin miscompares++; $display("FAIL cont_i_latency got %0d want 7", cyc); end
    if (i_rdata !== {64'hC3, 64'hC2, 64'hC1, 64'hC0}) begin miscompares++; $display("FAIL cont_i_line got %h want C3..C0", i_rdata); end
    @(negedge clk);
`ifdef PMEM_ARB_PERF_EN
    vectors += 3;
    if (perf_wait_cyc !== 32'd6) begin miscompares++; $display("FAIL perf_wait got %0d want 6", perf_wait_cyc); end
    if (perf_i_fills !== 32'd2) begin miscompares++; $display("FAIL perf_i_fills got %0d want 2", perf_i_fills); end
    if (perf_d_xfers !== 32'd2) begin miscompares++; $display("FAIL perf_d_xfers got %0d want 2", perf_d_xfers); end
`endif
  endtask

  task automatic test_stall;
    gap = 3;
    mem_tag = 64'hE0;
    i_address = 32'h0000_0FFF;
    exp_addr = 32'h0000_0FE0;
    i_read = 1'b1;
    wait_resp(60);
    i_read = 1'b0;
    gap = 1;
    vectors += 5;
    if (!got_i) begin miscompares++; $display("FAIL stall_owner got i=%b want 1", got_i); end
    if (cyc != 13) begin miscompares++; $display("FAIL stall_latency got %0d want 13", cyc); end
    if (rdhi != 12) begin miscompares++; $display("FAIL stall_read_cycles got %0d want 12", rdhi); end
    if (abad != 0) begin miscompares++; $display("FAIL stall_addr got %0d bad cycles want 0", abad); end
    if (i_rdata !== {64'hE3, 64'hE2, 64'hE1, 64'hE0}) begin miscompares++; $display("FAIL stall_line got %h want E3..E0", i_rdata); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    mem_tag = 64'hF0;
    d_address = 32'h0000_0040;
    d_read = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    d_read = 1'b0;
    @(negedge clk);
    vectors += 3;
    if (pmem_read !== 1'b0) begin miscompares++; $display("FAIL rstmid_read got %b want 0", pmem_read); end
    if (d_resp !== 1'b0) begin miscompares++; $display("FAIL rstmid_resp got %b want 0", d_resp); end
    if (d_rdata !== 256'h0) begin miscompares++; $display("FAIL rstmid_rdata got %h want 0", d_rdata); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (d_resp !== 1'b0) begin miscompares++; $display("FAIL rstmid_late_resp got %b want 0", d_resp); end
    mem_tag = 64'h70;
    i_address = 32'h0000_0080;
    exp_addr = 32'h0000_0080;
    i_read = 1'b1;
    wait_resp(40);
    i_read = 1'b0;
    vectors += 3;
    if (!(got_i && !got_d)) begin miscompares++; $display("FAIL rstmid_refill_owner got i=%b d=%b want i=1 d=0", got_i, got_d); end
    if (cyc != 6) begin miscompares++; $display("FAIL rstmid_refill_latency got %0d want 6", cyc); end
    if (i_rdata !== {64'h73, 64'h72, 64'h71, 64'h70}) begin miscompares++; $display("FAIL rstmid_refill_line got %h want 73..70", i_rdata); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    mem_tag = 64'h10;
    d_address = 32'h0000_0300;
    exp_addr = 32'h0000_0300;
    d_read = 1'b1;
    wait_resp(40);
    d_read = 1'b0;
    mem_tag = 64'h20;
    vectors += 2;
    if (!got_d) begin miscompares++; $display("FAIL b2b_first_owner got d=%b want 1", got_d); end
    if (d_rdata !== {64'h13, 64'h12, 64'h11, 64'h10}) begin miscompares++; $display("FAIL b2b_first_line got %h want 13..10", d_rdata); end
    @(negedge clk);
    vectors += 2;
    if (pmem_read !== 1'b0) begin miscompares++; $display("FAIL b2b_bubble_read got %b want 0", pmem_read); end
    if (d_resp !== 1'b0) begin miscompares++; $display("FAIL b2b_bubble_resp got %b want 0", d_resp); end
    d_address = 32'h0000_0320;
    exp_addr = 32'h0000_0320;
    d_read = 1'b1;
    wait_resp(40);
    d_read = 1'b0;
    vectors += 4;
    if (!(got_d && !got_i)) begin miscompares++; $display("FAIL b2b_second_owner got i=%b d=%b want i=0 d=1", got_i, got_d); end
    if (cyc != 6) begin miscompares++; $display("FAIL b2b_second_latency got %0d want 6", cyc); end
    if (abad != 0) begin miscompares++; $display("FAIL b2b_second_addr got %0d bad cycles want 0", abad); end
    if (d_rdata !== {64'h23, 64'h22, 64'h21, 64'h20}) begin miscompares++; $display("FAIL b2b_second_line got %h want 23..20", d_rdata); end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    i_address = '0; d_address = '0; d_wdata = '0;
    exp_addr = '0;
    test_reset;
    test_i_fill;
    test_d_write;
    test_contention;
    test_stall;
    test_reset_mid;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
